// File: rtl/updown_counter_param_if.sv
// Bus bundle for updown_counter_param: control inputs plus count/terminal/event outputs.
// The master side drives control; the slave side is the counter itself.
interface updown_counter_param_if #(
   parameter int unsigned WIDTH = 8
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             sat;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap;
   logic             sat_hit;

   modport master (
      output en, up, load, load_val, sat,
      input  count, tc, wrap, sat_hit
   );

   modport slave (
      input  en, up, load, load_val, sat,
      output count, tc, wrap, sat_hit
   );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with prescaler, parallel load, terminal count and wrap/saturate pulses.
// Saturation support is compiled in only when UPDOWN_COUNTER_SAT_EN is defined.
module updown_counter_param #(
   parameter int unsigned      WIDTH    = 8,
   parameter longint unsigned  MODULUS  = 256,
   parameter int unsigned      PRESCALE = 1
) (
   input logic                   clk,
   input logic                   reset,
   updown_counter_param_if.slave bus
);
   localparam int unsigned      PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MODULUS - 1);
   localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic             wrap_q, wrap_d;
   logic             at_end;
   logic             sat_mode;

`ifdef UPDOWN_COUNTER_SAT_EN
   logic sat_hit_q, sat_hit_d;

   assign sat_mode    = bus.sat;
   assign bus.sat_hit = sat_hit_q;
`else
   logic sat_unused;

   assign sat_mode    = 1'b0;
   assign sat_unused  = bus.sat;
   assign bus.sat_hit = 1'b0;
`endif

   // Range end in the current direction; doubles as the terminal-count output.
   assign at_end    = bus.up ? (count_q == MAX_C) : (count_q == '0);
   assign bus.tc    = at_end;
   assign bus.count = count_q;
   assign bus.wrap  = wrap_q;

   always_comb begin
      count_d = count_q;
      pre_d   = pre_q;
      wrap_d  = 1'b0;
`ifdef UPDOWN_COUNTER_SAT_EN
      sat_hit_d = 1'b0;
`endif
      if (bus.load) begin
         count_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
         pre_d   = '0;
      end else if (bus.en) begin
         if (pre_q != PRE_MAX) begin
            pre_d = pre_q + 1'b1;
         end else begin
            pre_d = '0;
            if (!at_end) begin
               count_d = bus.up ? (count_q + 1'b1) : (count_q - 1'b1);
            end else if (sat_mode) begin
`ifdef UPDOWN_COUNTER_SAT_EN
               sat_hit_d = 1'b1;
`endif
            end else begin
               count_d = bus.up ? '0 : MAX_C;
               wrap_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         pre_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         pre_q   <= pre_d;
         wrap_q  <= wrap_d;
      end
   end

`ifdef UPDOWN_COUNTER_SAT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         sat_hit_q <= 1'b0;
      end else begin
         sat_hit_q <= sat_hit_d;
      end
   end
`endif
endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations share one stimulus stream and are checked
// every cycle against a modular-arithmetic model, plus directed literal expectations.
module tb_updown_counter_param;
   logic       clk = 1'b0;
   logic       reset, en, up, load, sat;
   logic [7:0] load_val;

   int unsigned checks = 0;
   int unsigned errors = 0;
   bit          armed  = 1'b0;

   always #5 clk = ~clk;

   updown_counter_param_if #(.WIDTH(8)) ifa ();
   updown_counter_param_if #(.WIDTH(4)) ifb ();
   updown_counter_param_if #(.WIDTH(8)) ifc ();

   assign ifa.en = en;  assign ifa.up = up;  assign ifa.load = load;
   assign ifa.sat = sat; assign ifa.load_val = load_val;
   assign ifb.en = en;  assign ifb.up = up;  assign ifb.load = load;
   assign ifb.sat = sat; assign ifb.load_val = load_val[3:0];
   assign ifc.en = en;  assign ifc.up = up;  assign ifc.load = load;
   assign ifc.sat = sat; assign ifc.load_val = load_val;

   updown_counter_param #(.WIDTH(8), .MODULUS(256), .PRESCALE(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
   updown_counter_param #(.WIDTH(4), .MODULUS(10),  .PRESCALE(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
   updown_counter_param #(.WIDTH(8), .MODULUS(256), .PRESCALE(4)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

   logic [31:0] ocnt [3];
   logic        otc  [3];
   logic        owrp [3];
   logic        osat [3];
   assign ocnt[0] = 32'(ifa.count); assign otc[0] = ifa.tc; assign owrp[0] = ifa.wrap; assign osat[0] = ifa.sat_hit;
   assign ocnt[1] = 32'(ifb.count); assign otc[1] = ifb.tc; assign owrp[1] = ifb.wrap; assign osat[1] = ifb.sat_hit;
   assign ocnt[2] = 32'(ifc.count); assign otc[2] = ifc.tc; assign owrp[2] = ifc.wrap; assign osat[2] = ifc.sat_hit;

`ifdef UPDOWN_COUNTER_SAT_EN
   localparam bit SAT_BUILT = 1'b1;
`else
   localparam bit SAT_BUILT = 1'b0;
`endif
   localparam longint unsigned MODV [3] = '{256, 10, 256};
   localparam longint unsigned PREV [3] = '{1, 1, 4};
   localparam int unsigned     WV   [3] = '{8, 4, 8};

   longint unsigned mc [3];
   longint unsigned mp [3];
   bit              mw [3];
   bit              ms [3];

   task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
      end
   endtask

   // Reference: count lives in Z/MODULUS; a step crossing the range end either wraps or is blocked.
   always @(posedge clk) begin
      if (reset) armed = 1'b1;
      for (int i = 0; i < 3; i++) begin
         longint unsigned lv, nxt;
         bit              crossing;
         lv = load_val;
         lv = lv % (64'd1 << WV[i]);
         mw[i] = 1'b0;
         ms[i] = 1'b0;
         if (reset) begin
            mc[i] = 0;
            mp[i] = 0;
         end else if (load) begin
            mc[i] = (lv < MODV[i]) ? lv : MODV[i] - 1;
            mp[i] = 0;
         end else if (en) begin
            mp[i] = (mp[i] + 1) % PREV[i];
            if (mp[i] == 0) begin
               nxt      = (mc[i] + (up ? 1 : MODV[i] - 1)) % MODV[i];
               crossing = up ? (nxt == 0) : (nxt == MODV[i] - 1);
               if (crossing && SAT_BUILT && sat) ms[i] = 1'b1;
               else begin
                  mc[i] = nxt;
                  mw[i] = crossing;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_count%0d", i), ocnt[i], mc[i]);
            chk($sformatf("model_tc%0d", i), otc[i], up ? (mc[i] == MODV[i] - 1) : (mc[i] == 0));
            chk($sformatf("model_wrap%0d", i), owrp[i], mw[i]);
            chk($sformatf("model_sat_hit%0d", i), osat[i], ms[i]);
         end
      end
   end

   task automatic adv(input int unsigned n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0; sat = 1'b0;
      adv(2);
      chk("reset_count", ocnt[0], 0);
      chk("reset_wrap", owrp[0], 0);
      chk("reset_tc_up", otc[0], 0);

      reset = 1'b0;
      adv(1);   chk("run_count1", ocnt[0], 1);
      adv(254); chk("run_count255", ocnt[0], 255);
      chk("run_tc255", otc[0], 1);
      chk("run_wrap_pre", owrp[0], 0);
      adv(1);   chk("run_wrap_count", ocnt[0], 0);
      chk("run_wrap_pulse", owrp[0], 1);
      adv(1);   chk("run_after_wrap", ocnt[0], 1);
      chk("run_wrap_clear", owrp[0], 0);

      reset = 1'b1; up = 1'b0;
      adv(1);   chk("mod_reset_tc", otc[1], 1);
      reset = 1'b0;
      adv(1);   chk("mod_down_wrap", ocnt[1], 9);
      chk("mod_down_wrap_pulse", owrp[1], 1);
      adv(1);   chk("mod_down8", ocnt[1], 8);
      load = 1'b1; load_val = 8'd12;
      adv(1);   chk("mod_load_clamp", ocnt[1], 9);
      chk("wide_load12", ocnt[0], 12);
      load = 1'b0;

      reset = 1'b1; up = 1'b1;
      adv(1);
      reset = 1'b0;
      en = 1'b1; adv(1);
      en = 1'b1; adv(1);
      en = 1'b0; adv(1);
      en = 1'b1; adv(1); chk("pre_before_step", ocnt[2], 0);
      en = 1'b1; adv(1); chk("pre_first_step", ocnt[2], 1);
      adv(2);   chk("pre_mid", ocnt[2], 1);
      load = 1'b1; load_val = 8'd7;
      adv(1);   chk("pre_load", ocnt[2], 7);
      load = 1'b0;
      adv(3);   chk("pre_restart_hold", ocnt[2], 7);
      adv(1);   chk("pre_restart_step", ocnt[2], 8);

      reset = 1'b1;
      adv(1);
      reset = 1'b0; sat = 1'b1; up = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'd254;
      adv(1);   chk("sat_load254", ocnt[0], 254);
      load = 1'b0;
      adv(1);   chk("sat_step1", ocnt[0], 255);
      chk("sat_step1_flag", osat[0], 0);
      adv(1);
      if (SAT_BUILT) begin
         chk("sat_step2", ocnt[0], 255);
         chk("sat_step2_flag", osat[0], 1);
         chk("sat_step2_wrap", owrp[0], 0);
      end else begin
         chk("nosat_step2", ocnt[0], 0);
         chk("nosat_step2_wrap", owrp[0], 1);
         chk("nosat_step2_flag", osat[0], 0);
      end
      adv(1);
      chk("sat_step3", ocnt[0], SAT_BUILT ? 255 : 1);
      chk("sat_step3_flag", osat[0], SAT_BUILT ? 1 : 0);

      reset = 1'b1; load = 1'b1; load_val = 8'd5;
      adv(1);   chk("reset_over_load", ocnt[0], 0);
      reset = 1'b0; sat = 1'b0; load_val = 8'd255;
      adv(1);   chk("load255", ocnt[0], 255);
      load_val = 8'd5;
      adv(1);   chk("load_over_step", ocnt[0], 5);
      chk("load_over_step_wrap", owrp[0], 0);
      chk("load_over_step_sat", osat[0], 0);
      en = 1'b0; load_val = 8'd255;
      adv(1);   chk("flip_tc_before", otc[0], 1);
      load = 1'b0; up = 1'b0;
      #1;       chk("flip_tc_after", otc[0], 0);
      adv(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised up/down counter, the next generation of the fixed 8-bit free-running counter. Adds a configurable width and modulus, a count-enable prescaler, direction control, synchronous parallel load, terminal-count decode and wrap/saturate event flags. It is used standalone as a timer/event counter and as the count source for register banks built from `dffpr`-style flops.

## Interface
- `WIDTH`, 8: count width in bits; 2..32.
- `MODULUS`, 256: count range is 0..MODULUS-1; 2 <= MODULUS <= 2^WIDTH.
- `PRESCALE`, 1: number of enabled cycles per count step; 1..256.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable; it advances the prescaler.
- `up`  in  1  direction: 1 counts up, 0 counts down.
- `load`  in  1  synchronous parallel load.
- `load_val`  in  WIDTH  load value.
- `sat`  in  1  1 selects saturate at the range ends, 0 selects wrap (see Configuration).
- `count`  out  WIDTH  registered count value.
- `tc`  out  1  combinational terminal count: `count`==MODULUS-1 when `up`=1, or `count`==0 when `up`=0.
- `wrap`  out  1  registered one-cycle pulse when a step wrapped.
- `sat_hit`  out  1  registered one-cycle pulse when a step was blocked by saturation.

## Operation
- Internal prescaler `pre` has range 0..PRESCALE-1 and a width of clog2(PRESCALE), with a minimum of 1 bit.
- Priority per cycle is reset, then load, then step, then hold.
- **reset=1**
  - `count`=0, `pre`=0, `wrap`=0, `sat_hit`=0.
  - All other inputs are ignored that cycle.
- **load=1** (no reset)
  - `count` = `load_val` if `load_val` < MODULUS, otherwise MODULUS-1 (clamped).
  - `pre`=0, `wrap`=0, `sat_hit`=0.
  - `en` is ignored that cycle.
- **Prescaler**, when `en`=1 without load:
  - If `pre`==PRESCALE-1, a step occurs and `pre` returns to 0.
  - Otherwise `pre` increments and no step occurs.
  - With `en`=0, `pre` holds.
  - With PRESCALE=1, every enabled cycle is a step.
- **Step up**
  - If `count` < MODULUS-1: `count`+1.
  - If `count`==MODULUS-1 in wrap mode: `count`=0 and `wrap`=1.
  - If `count`==MODULUS-1 in saturate mode: `count` holds and `sat_hit`=1.
- **Step down**
  - If `count` > 0: `count`-1.
  - If `count`==0 in wrap mode: `count`=MODULUS-1 and `wrap`=1.
  - If `count`==0 in saturate mode: `count` holds and `sat_hit`=1.
- `wrap` and `sat_hit` are 0 on every cycle that does not produce the event; they are never both 1.
- Changing `up` or `sat` does not disturb `pre`; the new value applies to the next step.
- Arithmetic is modulo MODULUS, never modulo 2^WIDTH. With MODULUS < 2^WIDTH, `count` is never outside 0..MODULUS-1.

## Timing
- `count`, `wrap` and `sat_hit` update one cycle after the qualifying edge.
  - Load-to-output latency is 1 cycle.
  - The first step after reset or load occurs on the PRESCALE-th enabled cycle.
- `tc` has zero latency: it is combinational from `count` and `up`.
- After reset, `tc` = ~`up` (count is 0).
- A reset asserted mid-prescale discards the partial prescale.
- A load asserted mid-prescale restarts the prescale.
- Reset values: `count`=0, `wrap`=0, `sat_hit`=0.

## Configuration
- `UPDOWN_COUNTER_SAT_EN` defined:
  - Saturate logic and the `sat_hit` flop are compiled in.
  - `sat` selects saturate or wrap as described above.
- `UPDOWN_COUNTER_SAT_EN` undefined:
  - The `sat` port is present but ignored; the counter always wraps.
  - `sat_hit` is tied to 0.

## Test plan
- **Reset and free run.** WIDTH=8, MODULUS=256, PRESCALE=1, `up`=1, `en`=1, hold `reset` 2 cycles then release.
  - `count` reads 0,1,2,…; after 255 it reads 0, with `wrap`=1 for exactly that one cycle.
  - `tc`=1 while `count`=255.
- **Modulus and down count.** MODULUS=10, `up`=0, `en`=1 from reset.
  - `count` goes 0→9 with `wrap`=1, then 8,7,…; `tc`=1 at 0.
  - `load_val`=12 loads 9 (clamped).
- **Prescaler.** PRESCALE=4 with `en` toggling 1,1,0,1,1.
  - The first step occurs on the 4th enabled cycle, so `count`=1 after 5 clocks.
  - A load at `pre`=2 restarts the prescale, giving the next step 4 enabled cycles later.
- **Saturate.** With `UPDOWN_COUNTER_SAT_EN` defined, `sat`=1, load 254, step up 3 times.
  - `count` reads 255,255,255, with `sat_hit`=1 on the 2nd and 3rd steps and `wrap`=0.
  - Without the macro, the same stimulus gives 255,0,1 with a `wrap` pulse and `sat_hit` always 0.
- **Simultaneous events.**
  - `reset`=1 together with `load`=1 and `load_val`=5 gives `count`=0.
  - `load`=1 together with a step cycle gives `count`=`load_val`, with `wrap` and `sat_hit` both 0.
  - Flipping `up` at `count`=255 makes `tc` drop combinationally the same cycle.
